// File: rtl/serial_audio_pkg.sv
// Constants and state type shared by the audio serial link transmitter and the SIPO receiver.
package serial_audio_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Counts CLOCK_50 cycles within one serial bit; flags the last cycle and the mid-point cycle.
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic bit_mid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);
  assign bit_mid = (cnt == MID);

endmodule

// File: rtl/serial_audio_tx.sv
// Framed serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity is compiled in when SERIAL_AUDIO_TX_PARITY_EN is defined.
module serial_audio_tx
  import serial_audio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic       Serial_Out,
  output logic       Shift_Flag,
  output logic       Tx_Done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_end, bit_mid;
  logic                 accept, shift_en, frame_done, done_q;
  logic                 line_next, flag_next;
`ifdef SERIAL_AUDIO_TX_PARITY_EN
  logic                 parity_q;
`endif

  bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_period_counter (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .clear    (accept),
    .enable   (state != IDLE),
    .bit_end  (bit_end),
    .bit_mid  (bit_mid)
  );

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    line_next  = LINE_IDLE;
    flag_next  = 1'b0;
    case (state)
      IDLE: begin
        if (Tx_Valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_next = START_LEVEL;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        line_next = shreg[0];
        flag_next = bit_mid;
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_AUDIO_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_AUDIO_TX_PARITY_EN
      PARITY: begin
        line_next = parity_q;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg   <= Tx_Data;
      bit_idx <= '0;
    end else if (shift_en) begin
      shreg   <= shreg >> 1;
      bit_idx <= bit_idx + 1'b1;
    end
  end

`ifdef SERIAL_AUDIO_TX_PARITY_EN
  // Parity is captured at accept because the shift register empties as the data bits go out.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= even_parity(Tx_Data);
    end
  end
`endif

  // Outputs are registered from the current state, so the line lags the FSM by one cycle;
  // done_q adds the matching stage so Tx_Done lands with Tx_Ready.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      Serial_Out <= LINE_IDLE;
      Tx_Ready   <= 1'b1;
      Shift_Flag <= 1'b0;
      done_q     <= 1'b0;
      Tx_Done    <= 1'b0;
    end else begin
      Serial_Out <= line_next;
      Tx_Ready   <= (state == IDLE);
      Shift_Flag <= flag_next;
      done_q     <= frame_done;
      Tx_Done    <= done_q;
    end
  end

endmodule

// File: tb/tb_serial_audio_tx.sv
// Scoreboard bench for serial_audio_tx: expected frames are queued at issue, a monitor checks the line.
module tb_serial_audio_tx;

  localparam int CPB = 4;
  localparam int MID = CPB / 2;
`ifdef SERIAL_AUDIO_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       CLOCK_50 = 1'b0;
  logic       Reset    = 1'b1;
  logic [7:0] Tx_Data  = 8'h00;
  logic       Tx_Valid = 1'b0;
  logic       Tx_Ready, Serial_Out, Shift_Flag, Tx_Done;

  serial_audio_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .Tx_Data    (Tx_Data),
    .Tx_Valid   (Tx_Valid),
    .Tx_Ready   (Tx_Ready),
    .Serial_Out (Serial_Out),
    .Shift_Flag (Shift_Flag),
    .Tx_Done    (Tx_Done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cycle = 0;
  always @(posedge CLOCK_50) cycle <= cycle + 1;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference line level for bit slot idx of a frame carrying d.
  function automatic logic line_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR_EN && idx == 9) begin
      int ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(d[b]);
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  // Monitor: detects each start bit and checks the whole frame cycle by cycle.
  initial begin : monitor
    frame_t     f;
    int         end_cycle;
    logic [7:0] rx;
    end_cycle = -10;
    forever begin
      @(negedge CLOCK_50);
      if (Reset) continue;
      if (Serial_Out === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start bit, expected idle line (t=%0t)", $time);
          continue;
        end
        f = exp_q.pop_front();
        if (f.b2b) check("b2b_gap", cycle, end_cycle + 1);
        rx = 8'h00;
        for (int i = 0; i <= FRAME; i++) begin
          if (i > 0) @(negedge CLOCK_50);
          if (Reset) break;
          if (i < FRAME) begin
            check("serial_out", Serial_Out, line_bit(f.data, i / CPB));
            check("shift_flag", Shift_Flag, (i / CPB >= 1) && (i / CPB <= 8) && (i % CPB == MID));
            check("tx_done_busy", Tx_Done, 0);
            check("tx_ready_busy", Tx_Ready, 0);
            if (Shift_Flag === 1'b1) rx = {Serial_Out, rx[7:1]};
          end else begin
            check("tx_done_end", Tx_Done, 1);
            check("tx_ready_end", Tx_Ready, 1);
            check("line_idle_end", Serial_Out, 1);
            check("loopback_rx", rx, f.data);
            end_cycle = cycle;
          end
        end
      end else begin
        check("idle_tx_done", Tx_Done, 0);
        check("idle_shift_flag", Shift_Flag, 0);
      end
    end
  end

  // Counts edges from the current point until Tx_Done is seen and compares with the expected latency.
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    do begin
      @(posedge CLOCK_50);
      #1;
      n++;
    end while (Tx_Done !== 1'b1 && n < FRAME + 20);
    check(name, n, exp_lat);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge CLOCK_50);
    Tx_Data  = d;
    Tx_Valid = 1'b1;
    exp_q.push_back('{data: d, b2b: 1'b0});
    @(posedge CLOCK_50);
    #1;
    Tx_Valid = 1'b0;
    Tx_Data  = 8'($urandom);
    wait_done("done_latency", FRAME + 1);
  endtask

  // Two frames with Tx_Valid held high; Tx_Data changes right after the first accept.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    @(negedge CLOCK_50);
    Tx_Data  = a;
    Tx_Valid = 1'b1;
    exp_q.push_back('{data: a, b2b: 1'b0});
    exp_q.push_back('{data: b, b2b: 1'b1});
    @(posedge CLOCK_50);
    #1;
    Tx_Data = b;
    wait_done("pair_latency_1", FRAME + 1);
    Tx_Valid = 1'b0;
    Tx_Data  = 8'($urandom);
    wait_done("pair_latency_2", FRAME + 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #12;
    check("reset_serial_out", Serial_Out, 1);
    check("reset_tx_ready", Tx_Ready, 1);
    check("reset_tx_done", Tx_Done, 0);
    check("reset_shift_flag", Shift_Flag, 0);
    @(posedge CLOCK_50);
    #2;
    Reset = 1'b0;
    repeat (2) @(posedge CLOCK_50);

    send(8'hA5);
    send_pair(8'h01, 8'hFE);
    send(8'h00);
    send(8'hFF);
    send(8'h5A);

    // Reset in the middle of data bit 3, then an accept on the first edge after release.
    @(negedge CLOCK_50);
    Tx_Data  = 8'h3C;
    Tx_Valid = 1'b1;
    exp_q.push_back('{data: 8'h3C, b2b: 1'b0});
    @(posedge CLOCK_50);
    #1;
    Tx_Valid = 1'b0;
    repeat (4 * CPB + MID) @(posedge CLOCK_50);
    #2;
    check("pre_reset_busy", Tx_Ready, 0);
    Reset = 1'b1;
    #1;
    check("async_serial_out", Serial_Out, 1);
    check("async_tx_ready", Tx_Ready, 1);
    check("async_tx_done", Tx_Done, 0);
    check("async_shift_flag", Shift_Flag, 0);
    repeat (2) @(posedge CLOCK_50);
    #2;
    Reset    = 1'b0;
    Tx_Data  = 8'hC3;
    Tx_Valid = 1'b1;
    exp_q.push_back('{data: 8'hC3, b2b: 1'b0});
    @(posedge CLOCK_50);
    #1;
    Tx_Valid = 1'b0;
    Tx_Data  = 8'($urandom);
    wait_done("post_reset_latency", FRAME + 1);

    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
      if ($urandom_range(0, 3) == 0) send_pair(8'($urandom), 8'($urandom));
      else send(8'($urandom));
    end

    repeat (5) @(posedge CLOCK_50);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
